// File: rtl/uart_tx_byte_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_byte_fifo
//
// Purpose:
//   Byte FIFO that sits between the core's transmit-byte producer and the
//   UART transmitter's stream input. It absorbs bursts of bytes written by
//   the core. It presents the oldest byte first-word-fall-through on a
//   valid/ready master port. It raises a sticky flag when a push is
//   attempted while the FIFO is full. Single clock domain; the producer
//   strobe must already be synchronous to clk.
//
// Parameters:
//   WIDTH  data width in bits
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports:
//   clk       in   clock, all logic on the rising edge
//   nrst      in   asynchronous reset, active low
//   wr_en     in   push request, one word per cycle
//   wr_data   in   word to push
//   full      out  FIFO holds DEPTH entries
//   empty     out  FIFO holds no entries
//   count     out  current occupancy, 0..DEPTH
//   overflow  out  sticky, set when a push is attempted while full
//   clr_ovf   in   clears overflow (a simultaneous new overflow wins)
//   m_tdata   out  head-of-FIFO word
//   m_tvalid  out  head word valid (equals ~empty)
//   m_tready  in   downstream accepts the head word
// ---------------------------------------------------------------------------
module uart_tx_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  // Storage is deliberately left without reset; the pointers alone decide
  // which entries are meaningful.
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Pointers carry one extra lap bit above the address so that full and
  // empty can be told apart when the addresses coincide.
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [AW:0]      r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_wrAddr;
  logic [AW-1:0]    w_rdAddr;

  assign w_wrAddr = r_wrPtr[AW-1:0];
  assign w_rdAddr = r_rdPtr[AW-1:0];

  // Status depends on registered pointers only, so there is no
  // combinational path from wr_en or m_tready to full/empty/count.
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (w_wrAddr == w_rdAddr);
  assign w_empty = (r_wrPtr == r_rdPtr);

  // A push into a full FIFO is refused even if a pop happens on the same
  // edge; there is no pass-through of the incoming word.
  assign w_push = wr_en & ~w_full;
  assign w_pop  = m_tready & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wrAddr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE;
        2'b01:   r_count <= r_count - ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Set has priority over clear so that an overflow occurring in the same
  // cycle as an acknowledge is not lost.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_overflow <= 1'b0;
    end else if (wr_en && w_full) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign m_tvalid = ~w_empty;

  // Head word is forced to zero while empty so the unreset storage never
  // shows on the port (and the port reads zero out of reset).
  assign m_tdata  = w_empty ? '0 : r_mem[w_rdAddr];

endmodule
